// File: rtl/byte_serializer.sv
// byte_serializer
// Accepts bytes through a one-deep hold register with a valid/ready
// handshake and shifts them out MSB first, one bit per clock. Symbols are
// always 8 cycles long; when no byte is waiting at a symbol boundary the
// IDLE_SYM pattern is sent instead, so the line never goes silent.
module byte_serializer #(
  parameter logic [7:0] IDLE_SYM = 8'hBC
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       serial_out,
  output logic       valid_out,
  output logic       sym_start,
  output logic [7:0] data_cnt
);

  // Line state: INIT only until the first edge after reset, then the
  // state records what kind of symbol is currently in the shift register.
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0] state_q,     state_d;
  logic [7:0] hold_q,      hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] sh_q,        sh_d;
  logic [2:0] bit_cnt_q,   bit_cnt_d;
  logic [7:0] data_cnt_q,  data_cnt_d;

  logic boundary;
  logic accept;

  // A symbol boundary is the edge that ends the last bit of the current
  // symbol. Out of reset bit_cnt is 0, so the first edge is a boundary too.
  assign boundary = (bit_cnt_q == 3'd0);

  // The handshake only looks at registered state, so ready_out has no
  // combinational path from valid_in or data_in.
  assign ready_out = !hold_full_q && (state_q != ST_INIT);
  assign accept    = valid_in && ready_out;

  // Shift register, bit counter and symbol-type tracking.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    state_d    = state_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    data_cnt_d = data_cnt_q;
    if (boundary) begin
      bit_cnt_d = 3'd7;
      if (hold_full_q) begin
        sh_d       = hold_q;
        state_d    = ST_DATA;
        data_cnt_d = data_cnt_q + 8'd1;
      end else begin
        sh_d    = IDLE_SYM;
        state_d = ST_IDLE;
      end
    end else begin
      sh_d      = {sh_q[6:0], 1'b0};
      bit_cnt_d = bit_cnt_q - 3'd1;
    end
  end

  // Hold register: filled by the handshake, emptied when a boundary moves
  // its byte into the shift register. Both cannot happen on the same edge
  // because ready_out is low whenever hold is full.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (boundary && hold_full_q) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
  end

  // State registers; asynchronous reset drops any partial symbol and any
  // held byte immediately.
  always_ff @(posedge clk or negedge reset_L) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_L) begin
      state_q     <= ST_INIT;
      // NOTE: the hold byte is reset along with its flag so a byte held at
      // reset can never resurface, even though hold_full alone guards reads.
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      sh_q        <= 8'h00;
      bit_cnt_q   <= 3'd0;
      data_cnt_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      data_cnt_q  <= data_cnt_d;
    end
  end

  // Line outputs, all decoded from registers.
  assign serial_out = (state_q != ST_INIT) ? sh_q[7] : 1'b0;
  assign sym_start  = (bit_cnt_q == 3'd7) && (state_q != ST_INIT);
  assign valid_out  = (state_q == ST_DATA);
  assign data_cnt   = data_cnt_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Directed testbench for byte_serializer: idle pattern, single byte,
// back-to-back streaming, ignored data while not ready, mid-symbol reset
// and data counter wrap.
module tb_byte_serializer;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       serial_out;
  logic       valid_out;
  logic       sym_start;
  logic [7:0] data_cnt;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  byte_serializer #(.IDLE_SYM(8'hBC)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .serial_out (serial_out),
    .valid_out  (valid_out),
    .sym_start  (sym_start),
    .data_cnt   (data_cnt)
  );

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for two edges, release away from the edge. Leaves the DUT in INIT.
  task automatic do_reset();
    valid_in = 1'b0;
    data_in  = 8'h00;
    reset_L  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  // Tick until the next sym_start (at least one tick), bounded to 20 ticks.
  task automatic wait_sym(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sym_start && n < 20);
  endtask

  // Capture one symbol starting at the current cycle; ends on its last bit.
  task automatic get_sym(output logic [7:0] b, output logic [7:0] v,
                         output logic [7:0] s);
    b = 8'h00;
    v = 8'h00;
    s = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b = {b[6:0], serial_out};
      v = {v[6:0], valid_out};
      s = {s[6:0], sym_start};
      if (i < 7) tick();
    end
  endtask

  task automatic test_reset();
    reset_L  = 1'b0;
    valid_in = 1'b1;
    data_in  = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    n_run++;
    if ({ready_out, serial_out, valid_out, sym_start} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {ready_out, serial_out, valid_out, sym_start});
    end
    n_run++;
    if (data_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data_cnt: got %h expected 00", data_cnt);
    end
    valid_in = 1'b0;
    reset_L  = 1'b1;
    // Still INIT until the first edge after release.
    n_run++;
    if ({ready_out, serial_out} !== 2'b00) begin
      n_fail++;
      $display("FAIL init_after_release: got %b expected 00", {ready_out, serial_out});
    end
    tick();
    // First edge loads IDLE_SYM (MSB = 1) and opens the handshake.
    n_run++;
    if ({sym_start, serial_out, ready_out, valid_out} !== 4'b1110) begin
      n_fail++;
      $display("FAIL first_edge: got %b expected 1110",
               {sym_start, serial_out, ready_out, valid_out});
    end
  endtask

  task automatic test_idle();
    logic [7:0] b, v, s;
    do_reset();
    tick();
    for (int k = 0; k < 3; k++) begin
      get_sym(b, v, s);
      n_run++;
      if (b !== 8'hBC || v !== 8'h00 || s !== 8'h80) begin
        n_fail++;
        $display("FAIL idle_sym%0d: got bits %h valid %h start %h expected bc 00 80",
                 k, b, v, s);
      end
      tick();
    end
    n_run++;
    if (data_cnt !== 8'h00 || ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_cnt_ready: got cnt %h ready %b expected 00 1", data_cnt, ready_out);
    end
  endtask

  task automatic test_single();
    logic [7:0] b, v, s;
    int n;
    do_reset();
    tick();            // first bit of BC
    tick();
    tick();            // third bit of BC
    valid_in = 1'b1;
    data_in  = 8'hFF;
    tick();            // accepted on this edge
    valid_in = 1'b0;
    data_in  = 8'h00;
    n_run++;
    if (ready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ready_drop: got %b expected 0", ready_out);
    end
    // Five remaining BC bits before the boundary that loads FF.
    wait_sym(n);
    n_run++;
    if (n != 5 || sym_start !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency: got %0d ticks start %b expected 5 1", n, sym_start);
    end
    get_sym(b, v, s);
    n_run++;
    if (b !== 8'hFF || v !== 8'hFF || s !== 8'h80) begin
      n_fail++;
      $display("FAIL single_data: got bits %h valid %h start %h expected ff ff 80", b, v, s);
    end
    tick();
    get_sym(b, v, s);
    n_run++;
    if (b !== 8'hBC || v !== 8'h00) begin
      n_fail++;
      $display("FAIL single_resume_idle: got bits %h valid %h expected bc 00", b, v);
    end
    n_run++;
    if (data_cnt !== 8'h01) begin
      n_fail++;
      $display("FAIL single_data_cnt: got %h expected 01", data_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    logic       ser [48];
    logic       val [48];
    logic [7:0] got;
    logic       acc;
    int idx, first, nval;
    bytes[0] = 8'hFF;
    bytes[1] = 8'hEE;
    bytes[2] = 8'hDD;
    bytes[3] = 8'hCC;
    idx = 0;
    do_reset();
    for (int t = 0; t < 48; t++) begin
      ser[t] = serial_out;
      val[t] = valid_out;
      if (idx < 4) begin
        valid_in = 1'b1;
        data_in  = bytes[idx];
      end else begin
        valid_in = 1'b0;
      end
      acc = valid_in && ready_out;
      tick();
      if (acc) idx++;
    end
    valid_in = 1'b0;
    first = -1;
    for (int t = 47; t >= 0; t--) if (val[t]) first = t;
    // FF accepted after the first BC bit, so it starts right after that BC.
    n_run++;
    if (first != 9) begin
      n_fail++;
      $display("FAIL b2b_first_valid: got %0d expected 9", first);
    end
    nval = 0;
    for (int t = 9; t < 41; t++) if (val[t]) nval++;
    n_run++;
    if (nval != 32 || val[41] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_valid_run: got %0d high, tail %b expected 32 0", nval, val[41]);
    end
    for (int k = 0; k < 4; k++) begin
      got = 8'h00;
      for (int i = 0; i < 8; i++) got = {got[6:0], ser[9 + 8*k + i]};
      n_run++;
      if (got !== bytes[k]) begin
        n_fail++;
        $display("FAIL b2b_byte%0d: got %h expected %h", k, got, bytes[k]);
      end
    end
    n_run++;
    if (data_cnt !== 8'h04 || idx != 4) begin
      n_fail++;
      $display("FAIL b2b_data_cnt: got cnt %h accepted %0d expected 04 4", data_cnt, idx);
    end
  endtask

  task automatic test_ignore();
    logic [7:0] got;
    int nval;
    do_reset();
    tick();
    valid_in = 1'b1;
    data_in  = 8'h11;
    tick();            // 11 accepted
    got  = 8'h00;
    nval = 0;
    for (int t = 0; t < 30; t++) begin
      if (valid_out) begin
        got = {got[6:0], serial_out};
        nval++;
      end
      data_in  = 8'h77;
      valid_in = !ready_out;   // offer 77 only while the DUT is not ready
      tick();
    end
    valid_in = 1'b0;
    n_run++;
    if (nval != 8 || got !== 8'h11) begin
      n_fail++;
      $display("FAIL ignore_not_ready: got %0d bits value %h expected 8 11", nval, got);
    end
    n_run++;
    if (data_cnt !== 8'h01) begin
      n_fail++;
      $display("FAIL ignore_data_cnt: got %h expected 01", data_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b, v, s;
    int n, nval;
    do_reset();
    tick();
    valid_in = 1'b1;
    data_in  = 8'hAA;
    tick();            // AA accepted
    valid_in = 1'b0;
    wait_sym(n);       // AA first bit
    valid_in = 1'b1;
    data_in  = 8'h99;
    tick();            // 99 accepted, AA second bit
    valid_in = 1'b0;
    tick();            // AA third bit (1)
    n_run++;
    if ({valid_out, serial_out, ready_out} !== 3'b110) begin
      n_fail++;
      $display("FAIL midrst_precond: got %b expected 110", {valid_out, serial_out, ready_out});
    end
    #2;
    reset_L = 1'b0;
    #1;                // well before the next edge
    n_run++;
    if ({ready_out, serial_out, valid_out, sym_start} !== 4'b0000 || data_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_async: got %b cnt %h expected 0000 00",
               {ready_out, serial_out, valid_out, sym_start}, data_cnt);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_L = 1'b1;
    tick();
    get_sym(b, v, s);
    n_run++;
    if (b !== 8'hBC || v !== 8'h00 || s !== 8'h80) begin
      n_fail++;
      $display("FAIL midrst_first_sym: got bits %h valid %h start %h expected bc 00 80",
               b, v, s);
    end
    nval = 0;
    for (int t = 0; t < 24; t++) begin
      tick();
      if (valid_out) nval++;
    end
    n_run++;
    if (nval != 0 || data_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_discard: got %0d valid cycles cnt %h expected 0 00", nval, data_cnt);
    end
  endtask

  task automatic test_wrap();
    logic       acc;
    logic [7:0] exp_cnt;
    int idx, starts;
    do_reset();
    idx    = 0;
    starts = 0;
    for (int c = 0; c < 2400 && starts < 257; c++) begin
      if (sym_start && valid_out) begin
        starts++;
        case (starts)
          1:   exp_cnt = 8'h01;
          255: exp_cnt = 8'hFF;
          256: exp_cnt = 8'h00;
          257: exp_cnt = 8'h01;
          default: exp_cnt = 8'hXX;
        endcase
        if (starts == 1 || starts >= 255) begin
          n_run++;
          if (data_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL wrap_cnt_byte%0d: got %h expected %h", starts, data_cnt, exp_cnt);
          end
        end
      end
      valid_in = (idx < 257);
      data_in  = idx[7:0];
      acc      = valid_in && ready_out;
      tick();
      if (acc) idx++;
    end
    valid_in = 1'b0;
    n_run++;
    if (starts != 257) begin
      n_fail++;
      $display("FAIL wrap_timeout: got %0d data symbols expected 257", starts);
    end
  endtask

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 Parameter IDLE_SYM, default 8'hBC, SHALL be the symbol transmitted when no data byte is pending.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_L  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 data_in  input  8  SHALL be the byte offered by the upstream 4:1 byte mux.
REQ-005 valid_in  input  1  SHALL qualify data_in.
REQ-006 ready_out  output  1  SHALL be high when a byte can be accepted this cycle.
REQ-007 serial_out  output  1  SHALL be the current serial bit, MSB first.
REQ-008 valid_out  output  1  SHALL be high while a data bit (not IDLE_SYM) is on serial_out.
REQ-009 sym_start  output  1  SHALL be high during the first (MSB) bit of every symbol.
REQ-010 data_cnt  output  8  SHALL be the count of data bytes started on the line.

Function
REQ-011 Internal state SHALL be an 8-bit hold register, a hold_full flag, an 8-bit shift register (sh), a 3-bit bit counter (bit_cnt) and a 3-state FSM: INIT, IDLE, DATA.
REQ-012 Handshake: a byte SHALL be accepted on a rising edge where valid_in=1 and ready_out=1, writing hold and setting hold_full.
REQ-013 ready_out SHALL equal (!hold_full && state!=INIT), decoded from registers only.
REQ-014 Data offered while ready_out=0 SHALL be ignored; the byte SHALL NOT bypass hold into sh.
REQ-015 Symbol boundary: on any edge where bit_cnt==0, sh SHALL load hold with state->DATA and hold_full cleared if hold_full=1, otherwise IDLE_SYM with state->IDLE; bit_cnt SHALL load 7.
REQ-016 On non-boundary edges sh SHALL shift left by one and bit_cnt SHALL decrement by 1.
REQ-017 serial_out SHALL equal sh[7] in IDLE/DATA and 0 in INIT.
REQ-018 sym_start SHALL equal (bit_cnt==7 && state!=INIT); valid_out SHALL equal (state==DATA).
REQ-019 data_cnt SHALL increment by 1 on each boundary edge that loads a data byte, wrapping 255->0.
REQ-020 INIT SHALL last exactly until the first rising edge after reset release, which SHALL be a boundary that loads IDLE_SYM.
REQ-021 Latency: a byte accepted at edge N SHALL appear on serial_out from the first boundary edge at or after N+1, occupying exactly 8 cycles.
REQ-022 A byte accepted during an in-flight symbol SHALL follow it with no gap, so back-to-back bytes stream contiguously with no IDLE_SYM between.
REQ-023 An accept edge coinciding with a boundary edge that drains hold is impossible (ready_out=0 while hold_full); no simultaneous write/drain path SHALL exist.

Reset
REQ-024 While reset_L=0: state=INIT, sh=0, bit_cnt=0, hold=0, hold_full=0, data_cnt=0; ready_out, serial_out, valid_out and sym_start SHALL all be 0.
REQ-025 Reset asserted mid-symbol SHALL abandon the partial symbol and discard any held byte immediately, without waiting for a clock edge.

Verification
REQ-026 Reset release, valid_in=0 -> serial_out repeats 1,0,1,1,1,1,0,0 every 8 cycles; sym_start pulses every 8th cycle; valid_out=0; data_cnt=0.
REQ-027 Single byte 8'hFF offered mid-idle -> ready_out drops the following cycle; after the current 8'hBC completes, eight 1s are output with valid_out=1, then 8'hBC resumes; data_cnt=1.
REQ-028 valid_in held high with FF, EE, DD, CC each presented until accepted -> output is FF EE DD CC contiguously with valid_out continuously high for 32 cycles; data_cnt=4.
REQ-029 data_in changed to 8'h77 while ready_out=0 -> 8'h77 is never emitted; only accepted bytes appear on serial_out.
REQ-030 reset_L pulled low during bit 3 of 8'hAA with 8'h99 held -> all outputs 0 at once; after release, first symbol is 8'hBC and 8'h99 is never sent.
REQ-031 256 consecutive data bytes -> data_cnt returns to 0 at the start of the 256th byte and reads 1 at the start of the 257th.
